// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - windowed error-metric monitor for 8x8 approximate multipliers
module approx_mult_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [15:0]      R_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_ed,
    output logic [15:0]      max_ed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic        accept;
    logic        last_accept;
    logic        win_start;
    logic        s1_valid, s2_valid;
    logic [15:0] s1_exact, s1_approx;
    logic [15:0] s2_ed;
    logic [SUM_W:0] sum_next;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign win_start   = start && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_accept) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Nothing new enters after the window fills, so an empty S1
                // behind a valid S2 means the final sample is retiring now.
                if (s2_valid && !s1_valid) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
            s2_ed     <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                s1_exact  <= {8'd0, A} * {8'd0, B};
                s1_approx <= R_approx;
            end
            if (s1_valid) begin
                s2_ed <= (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                                 : (s1_approx - s1_exact);
            end
        end
    end

    assign sum_next = {1'b0, sum_ed} + {{(SUM_W - 15){1'b0}}, s2_ed};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (win_start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (s2_valid) begin
                if (s2_ed != 16'd0 && err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                sum_ed <= sum_next[SUM_W] ? '1 : sum_next[SUM_W-1:0];
                if (s2_ed > max_ed) begin
                    max_ed <= s2_ed;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - directed self-checking bench for approx_mult_err_monitor
`timescale 1ns/1ps
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [15:0] R_approx = '0;

    // Instance a: N_SAMPLES=4, SUM_W=32
    logic        start_a = 1'b0;
    logic        in_ready_a, busy_a, done_a;
    logic [15:0] sample_cnt_a, err_cnt_a, max_ed_a;
    logic [31:0] sum_ed_a;

    // Instance b: N_SAMPLES=3, SUM_W=17
    logic        start_b = 1'b0;
    logic        in_ready_b, busy_b, done_b;
    logic [15:0] sample_cnt_b, err_cnt_b, max_ed_b;
    logic [16:0] sum_ed_b;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.N_SAMPLES(4), .SUM_W(32), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid),
        .in_ready(in_ready_a), .A(A), .B(B), .R_approx(R_approx),
        .busy(busy_a), .done(done_a), .sample_cnt(sample_cnt_a),
        .err_cnt(err_cnt_a), .sum_ed(sum_ed_a), .max_ed(max_ed_a)
    );

    approx_mult_err_monitor #(.N_SAMPLES(3), .SUM_W(17), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid),
        .in_ready(in_ready_b), .A(A), .B(B), .R_approx(R_approx),
        .busy(busy_b), .done(done_b), .sample_cnt(sample_cnt_b),
        .err_cnt(err_cnt_b), .sum_ed(sum_ed_b), .max_ed(max_ed_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample for exactly one edge, then deasserts in_valid.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        R_approx = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ready"}, in_ready_a, 0);
        check({tag, "_busy"},  busy_a, 0);
        check({tag, "_done"},  done_a, 0);
        check({tag, "_cnt"},   sample_cnt_a, 0);
        check({tag, "_err"},   err_cnt_a, 0);
        check({tag, "_sum"},   sum_ed_a, 0);
        check({tag, "_max"},   max_ed_a, 0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check_idle_a("rst_a");
        check("rst_b_ready", in_ready_b, 0);
        check("rst_b_busy",  busy_b, 0);
        check("rst_b_sum",   sum_ed_b, 0);

        // Exact products on a, back to back
        start_a = 1'b1; step(); start_a = 1'b0;
        check("ex_ready", in_ready_a, 1);
        check("ex_busy",  busy_a, 1);
        send(8'd3, 8'd5, 16'd15);
        send(8'd255, 8'd255, 16'd65025);
        send(8'd0, 8'd7, 16'd0);
        check("ex_cnt3", sample_cnt_a, 3);
        send(8'd16, 8'd16, 16'd256);
        check("ex_drain_ready", in_ready_a, 0);
        check("ex_drain_busy",  busy_a, 1);
        check("ex_done_k",      done_a, 0);
        step();
        check("ex_done_k1",     done_a, 0);
        step();
        check("ex_done_k2",     done_a, 1);
        check("ex_cnt", sample_cnt_a, 4);
        check("ex_err", err_cnt_a, 0);
        check("ex_sum", sum_ed_a, 0);
        check("ex_max", max_ed_a, 0);
        step();
        check("ex_done_k3", done_a, 0);
        check("ex_idle_busy", busy_a, 0);

        // Mixed errors on b, including R_approx above exact
        start_b = 1'b1; step(); start_b = 1'b0;
        send(8'd255, 8'd255, 16'd0);
        send(8'd2, 8'd3, 16'd10);
        send(8'd4, 8'd4, 16'd16);
        step();
        step();
        check("mix_done", done_b, 1);
        check("mix_cnt",  sample_cnt_b, 3);
        check("mix_err",  err_cnt_b, 2);
        check("mix_sum",  sum_ed_b, 65029);
        check("mix_max",  max_ed_b, 65025);
        step();

        // Saturation of the 17-bit sum on b
        start_b = 1'b1; step(); start_b = 1'b0;
        check("sat_cleared", sum_ed_b, 0);
        repeat (3) send(8'd255, 8'd255, 16'd0);
        step();
        step();
        check("sat_done", done_b, 1);
        check("sat_sum",  sum_ed_b, 131071);
        check("sat_max",  max_ed_b, 65025);
        check("sat_err",  err_cnt_b, 3);
        step();
        check("sat_hold", sum_ed_b, 131071);

        // Gapped valid pattern 1,0,1,0,0,1,1 on a with a stray start in RUN
        start_a = 1'b1; step(); start_a = 1'b0;
        send(8'd1, 8'd1, 16'd3);             // ED 2
        step();
        send(8'd10, 8'd10, 16'd90);          // ED 10
        start_a = 1'b1; step(); start_a = 1'b0;
        check("gap_start_ign_busy", busy_a, 1);
        check("gap_start_ign_cnt",  sample_cnt_a, 2);
        step();
        send(8'd3, 8'd3, 16'd9);             // ED 0
        send(8'd0, 8'd0, 16'd5);             // ED 5
        check("gap_ready_drop", in_ready_a, 0);
        send(8'd255, 8'd255, 16'd0);         // offered in DRAIN, must be ignored
        check("gap_done_k1", done_a, 0);
        step();
        check("gap_done", done_a, 1);
        check("gap_cnt",  sample_cnt_a, 4);
        check("gap_err",  err_cnt_a, 3);
        check("gap_sum",  sum_ed_a, 17);
        check("gap_max",  max_ed_a, 10);
        start_a = 1'b1; step(); start_a = 1'b0;  // start in DONE is ignored
        check("done_start_ign_busy", busy_a, 0);
        check("done_start_ign_sum",  sum_ed_a, 17);
        start_a = 1'b1; step(); start_a = 1'b0;  // start in the following IDLE is honoured
        check("idle_start_busy", busy_a, 1);
        check("idle_start_sum",  sum_ed_a, 0);

        // Reset after 2 of 4 samples
        send(8'd200, 8'd2, 16'd0);
        send(8'd9, 8'd9, 16'd1);
        step();
        rst = 1'b1;
        #1;
        check_idle_a("mid_rst");
        step();
        rst = 1'b0;
        begin
            int seen_done = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (done_a || busy_a) seen_done++;
            end
            check("mid_rst_quiet", seen_done, 0);
        end
        check_idle_a("post_rst");

        // Clean window after reset
        start_a = 1'b1; step(); start_a = 1'b0;
        send(8'd2, 8'd2, 16'd5);             // ED 1
        send(8'd7, 8'd8, 16'd56);
        send(8'd100, 8'd100, 16'd10000);
        send(8'd1, 8'd0, 16'd0);
        begin
            int waited = 0;
            while (!done_a && waited < 10) begin
                step();
                waited++;
            end
            check("clean_wait", waited, 2);
        end
        check("clean_done", done_a, 1);
        check("clean_cnt",  sample_cnt_a, 4);
        check("clean_err",  err_cnt_a, 1);
        check("clean_sum",  sum_ed_a, 1);
        check("clean_max",  max_ed_a, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
